// File: rtl/vending_machine_pkg.sv
// Shared definitions for the vending machine: FSM state encoding, coin values,
// price table, stock sizing and the BCD / 7-segment helpers used by the display.
package vending_machine_pkg;

  // Purchase FSM state encoding (kept as plain constants for legacy tools).
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_COIN   = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_VEND   = 3'd3;
  localparam logic [2:0] ST_CHANGE = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;

  localparam logic [7:0] COIN1_VALUE = 8'd1;
  localparam logic [7:0] COIN2_VALUE = 8'd2;
  localparam logic [7:0] COIN5_VALUE = 8'd5;
  localparam logic [7:0] CREDIT_MAX  = 8'd99;

  localparam int NUM_ITEMS          = 4;
  localparam int STOCK_W            = 4;
  localparam int INIT_STOCK_DEFAULT = 5;

  typedef logic [STOCK_W-1:0] stock_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  function automatic logic [7:0] base_price(input logic [1:0] item);
    case (item)
      2'd0:    return 8'd3;
      2'd1:    return 8'd4;
      2'd2:    return 8'd6;
      default: return 8'd7;
    endcase
  endfunction

  // Scarcity pricing: the last unit (and a sold-out slot) costs one more.
  function automatic logic [7:0] item_price(input logic [1:0] item, input stock_t stock);
    return base_price(item) + ((stock <= stock_t'(1)) ? 8'd1 : 8'd0);
  endfunction

  // Values are bounded to 0..99 by the credit saturation, so two digits suffice.
  function automatic bcd2_t to_bcd2(input logic [7:0] value);
    bcd2_t r;
    r.tens = 4'(value / 8'd10);
    r.ones = 4'(value % 8'd10);
    return r;
  endfunction

  // Segment order is seg[6:0] = {g,f,e,d,c,b,a}; result is active-low.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] on;
    case (digit)
      4'd0:    on = 7'h3F;
      4'd1:    on = 7'h06;
      4'd2:    on = 7'h5B;
      4'd3:    on = 7'h4F;
      4'd4:    on = 7'h66;
      4'd5:    on = 7'h6D;
      4'd6:    on = 7'h7D;
      4'd7:    on = 7'h07;
      4'd8:    on = 7'h7F;
      4'd9:    on = 7'h6F;
      default: on = 7'h00;
    endcase
    return ~on;
  endfunction

endpackage

// File: rtl/vending_machine_if.sv
// Bus between the purchase controller and the inventory, plus the controller
// status it publishes.
//   master  : controller side (item selects, decrement, status out; stocks in)
//   slave   : inventory side (item selects, decrement in; stocks out)
//   monitor : read-only view of everything
interface vending_machine_if;
  import vending_machine_pkg::*;

  logic [1:0] sel_item;    // item shown to the user (sw_item)
  stock_t     sel_stock;   // stock of sel_item
  logic [1:0] vend_item;   // item latched for the purchase in flight
  stock_t     vend_stock;  // stock of vend_item
  logic       vend_dec;    // decrement vend_item this cycle
  logic [7:0] credit;
  logic [7:0] change_due;
  logic [2:0] state;
  logic       vend_pulse;
  logic       error_flag;

  modport master (
    output sel_item, vend_item, vend_dec, credit, change_due, state, vend_pulse, error_flag,
    input  sel_stock, vend_stock
  );

  modport slave (
    input  sel_item, vend_item, vend_dec,
    output sel_stock, vend_stock
  );

  modport monitor (
    input sel_item, sel_stock, vend_item, vend_stock, vend_dec,
          credit, change_due, state, vend_pulse, error_flag
  );
endinterface

// File: rtl/debounce.sv
// Push-button conditioner: two-flop synchronizer, stability-count debouncer and
// rising-edge detector.
//   clk, rst  : clock, synchronous active-low reset
//   btn_raw   : asynchronous raw button level
//   btn_pulse : one-clock pulse per accepted press
// The debounced level follows the synchronized input once it has held a new
// value for CNTR_MAX+1 consecutive clocks (CNTR_MAX must be >= 1).
module debounce #(
  parameter int CNTR_MAX = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_pulse
);
  localparam int CNT_W = $clog2(CNTR_MAX + 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_prev_q, level_prev_d;

  always_comb begin
    sync_d       = {sync_q[0], btn_raw};
    cnt_d        = cnt_q;
    level_d      = level_q;
    level_prev_d = level_q;
    if (sync_q[1] == level_q) begin
      // Any return to the current level restarts the stability window.
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(CNTR_MAX)) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
    end
  end

  assign btn_pulse = level_q & ~level_prev_q;
endmodule

// File: rtl/inventory.sv
// Per-item stock counters.
//   clk, rst     : clock, synchronous active-low reset
//   restock      : level; reloads every item to INIT_STOCK while high
//   bus (slave)  : item selects / decrement in, selected stocks out
module inventory
  import vending_machine_pkg::*;
#(
  parameter int INIT_STOCK = INIT_STOCK_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic restock,
  vending_machine_if.slave bus
);
  logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_all;

  generate
    for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_item
      stock_t stock_q, stock_d;

      always_comb begin
        stock_d = stock_q;
        // Restock overrides a same-cycle decrement; an empty slot stays empty.
        if (restock) begin
          stock_d = stock_t'(INIT_STOCK);
        end else if (bus.vend_dec && bus.vend_item == 2'(gi) && stock_q != '0) begin
          stock_d = stock_q - 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          stock_q <= stock_t'(INIT_STOCK);
        end else begin
          stock_q <= stock_d;
        end
      end

      assign stock_all[gi] = stock_q;
    end
  endgenerate

  assign bus.sel_stock  = stock_all[bus.sel_item];
  assign bus.vend_stock = stock_all[bus.vend_item];
endmodule

// File: rtl/seg7_driver.sv
// Four-digit multiplexed 7-segment driver.
//   clk, rst : clock, synchronous active-low reset
//   credit   : shown on digits 3..2 (BCD)
//   price    : shown on digits 1..0 (BCD)
//   seg      : segments {g..a}, active-low
//   an       : anodes, active-low, one digit lit per REFRESH_COUNT clocks
module seg7_driver
  import vending_machine_pkg::*;
#(
  parameter int REFRESH_COUNT = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] credit,
  input  logic [7:0] price,
  output logic [6:0] seg,
  output logic [3:0] an
);
  localparam int REF_W = $clog2(REFRESH_COUNT + 1);

  logic [REF_W-1:0] refresh_q, refresh_d;
  logic [1:0]       digit_q, digit_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  bcd2_t      credit_bcd;
  bcd2_t      price_bcd;
  logic [3:0] nibble;

  assign credit_bcd = to_bcd2(credit);
  assign price_bcd  = to_bcd2(price);

  always_comb begin
    case (digit_q)
      2'd0:    nibble = price_bcd.ones;
      2'd1:    nibble = price_bcd.tens;
      2'd2:    nibble = credit_bcd.ones;
      default: nibble = credit_bcd.tens;
    endcase
  end

  always_comb begin
    refresh_d = refresh_q + 1'b1;
    digit_d   = digit_q;
    if (refresh_q == REF_W'(REFRESH_COUNT - 1)) begin
      refresh_d = '0;
      digit_d   = digit_q + 1'b1;
    end
    // Anode and segments are registered together so they never disagree.
    an_d  = ~(4'b0001 << digit_q);
    seg_d = seg_encode(nibble);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      refresh_q <= '0;
      digit_q   <= '0;
      seg_q     <= 7'h7F;
      an_q      <= 4'b1111;
    end else begin
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
endmodule

// File: rtl/vend_ctrl.sv
// Purchase controller: credit accumulation and the IDLE/COIN/CHECK/VEND/
// CHANGE/ERROR sequence.
//   clk, rst         : clock, synchronous active-low reset
//   coin*_pulse      : one-clock coin pulses ($1/$2/$5)
//   purchase_pulse   : one-clock purchase pulse
//   sw_item          : selected item
//   bus (master)     : inventory access and published status
//   price_disp       : current price of the selected item
module vend_ctrl
  import vending_machine_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        coin1_pulse,
  input  logic        coin2_pulse,
  input  logic        coin5_pulse,
  input  logic        purchase_pulse,
  input  logic [1:0]  sw_item,
  vending_machine_if.master bus,
  output logic [7:0]  price_disp
);
  logic [2:0] state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic [7:0] change_q, change_d;
  logic [1:0] item_q, item_d;
  logic [7:0] price_q, price_d;

  logic       coin_any;
  logic [7:0] coin_value;
  logic [7:0] coin_sum;

  assign price_disp = item_price(sw_item, bus.sel_stock);

  // Simultaneous coins are resolved by value; only one is credited.
  always_comb begin
    coin_any   = coin1_pulse | coin2_pulse | coin5_pulse;
    coin_value = COIN1_VALUE;
    if (coin5_pulse) begin
      coin_value = COIN5_VALUE;
    end else if (coin2_pulse) begin
      coin_value = COIN2_VALUE;
    end
    // credit <= 99 so the sum cannot wrap 8 bits.
    coin_sum = credit_q + coin_value;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    item_d   = item_q;
    price_d  = price_q;
    case (state_q)
      ST_IDLE: begin
        // A coin wins over a purchase in the same cycle; the purchase is lost.
        if (coin_any) begin
          state_d  = ST_COIN;
          credit_d = (coin_sum > CREDIT_MAX) ? CREDIT_MAX : coin_sum;
        end else if (purchase_pulse) begin
          state_d = ST_CHECK;
          item_d  = sw_item;
          price_d = price_disp;
        end
      end
      ST_COIN:  state_d = ST_IDLE;
      ST_CHECK: begin
        if (bus.vend_stock == '0 || credit_q < price_q) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_VEND;
        end
      end
      ST_VEND:  state_d = ST_CHANGE;
      ST_CHANGE: begin
        change_d = credit_q - price_q;
        credit_d = credit_q - price_q;
        state_d  = ST_IDLE;
      end
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      change_q <= '0;
      item_q   <= '0;
      price_q  <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      item_q   <= item_d;
      price_q  <= price_d;
    end
  end

  assign bus.sel_item   = sw_item;
  assign bus.vend_item  = item_q;
  assign bus.vend_dec   = (state_q == ST_VEND);
  assign bus.credit     = credit_q;
  assign bus.change_due = change_q;
  assign bus.state      = state_q;
  assign bus.vend_pulse = (state_q == ST_VEND);
  assign bus.error_flag = (state_q == ST_ERROR);
endmodule

// File: rtl/vending_machine_top.sv
// Vending machine top: button conditioning, purchase controller, inventory,
// display and buzzer tone generator.
//   clk, rst       : clock, synchronous active-low reset
//   btn_*          : raw push-buttons (coin1/coin2/coin5/purchase)
//   sw_item        : item select; restock: level reload of all stocks
//   seg/an         : multiplexed 7-segment display (active-low)
//   stock_level    : stock of the selected item
//   leds           : {sold_out, credit>=price, error, vend/tone, item one-hot}
//   audio_out/sd   : buzzer square wave and amplifier enable
module vending_machine_top
  import vending_machine_pkg::*;
#(
  parameter int DEBOUNCE_MAX  = 1_000_000,
  parameter int REFRESH_COUNT = 100_000,
  parameter int INIT_STOCK    = 5,
  parameter int TONE_DIV      = 50_000,
  parameter int TONE_LEN      = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_coin1,
  input  logic       btn_coin2,
  input  logic       btn_coin5,
  input  logic       btn_purchase,
  input  logic [1:0] sw_item,
  input  logic       restock,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [3:0] stock_level,
  output logic [7:0] leds,
  output logic       audio_out,
  output logic       audio_sd
);
  localparam int TONE_W = $clog2(TONE_LEN + 1);
  localparam int DIV_W  = $clog2(TONE_DIV + 1);

  vending_machine_if vm_bus ();

  logic       coin1_pulse, coin2_pulse, coin5_pulse, purchase_pulse;
  logic [7:0] price_disp;

  debounce #(.CNTR_MAX(DEBOUNCE_MAX)) db0 (.clk(clk), .rst(rst), .btn_raw(btn_coin1),    .btn_pulse(coin1_pulse));
  debounce #(.CNTR_MAX(DEBOUNCE_MAX)) db1 (.clk(clk), .rst(rst), .btn_raw(btn_coin2),    .btn_pulse(coin2_pulse));
  debounce #(.CNTR_MAX(DEBOUNCE_MAX)) db2 (.clk(clk), .rst(rst), .btn_raw(btn_coin5),    .btn_pulse(coin5_pulse));
  debounce #(.CNTR_MAX(DEBOUNCE_MAX)) db3 (.clk(clk), .rst(rst), .btn_raw(btn_purchase), .btn_pulse(purchase_pulse));

  vend_ctrl ctrl (
    .clk           (clk),
    .rst           (rst),
    .coin1_pulse   (coin1_pulse),
    .coin2_pulse   (coin2_pulse),
    .coin5_pulse   (coin5_pulse),
    .purchase_pulse(purchase_pulse),
    .sw_item       (sw_item),
    .bus           (vm_bus.master),
    .price_disp    (price_disp)
  );

  inventory #(.INIT_STOCK(INIT_STOCK)) inv (
    .clk    (clk),
    .rst    (rst),
    .restock(restock),
    .bus    (vm_bus.slave)
  );

  seg7_driver #(.REFRESH_COUNT(REFRESH_COUNT)) seg7 (
    .clk   (clk),
    .rst   (rst),
    .credit(vm_bus.credit),
    .price (price_disp),
    .seg   (seg),
    .an    (an)
  );

  // Tone generator: a vend (re)starts a TONE_LEN burst; the square wave flips
  // every TONE_DIV clocks and parks low when the burst ends.
  logic [TONE_W-1:0] tone_q, tone_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              audio_q, audio_d;

  always_comb begin
    tone_d  = tone_q;
    div_d   = div_q;
    audio_d = audio_q;
    if (vm_bus.vend_pulse) begin
      tone_d  = TONE_W'(TONE_LEN);
      div_d   = '0;
      audio_d = 1'b0;
    end else if (tone_q != '0) begin
      tone_d = tone_q - 1'b1;
      if (div_q == DIV_W'(TONE_DIV - 1)) begin
        div_d   = '0;
        audio_d = ~audio_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end else begin
      div_d   = '0;
      audio_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tone_q  <= '0;
      div_q   <= '0;
      audio_q <= 1'b0;
    end else begin
      tone_q  <= tone_d;
      div_q   <= div_d;
      audio_q <= audio_d;
    end
  end

  logic tone_active;
  assign tone_active = (tone_q != '0);

  assign audio_out   = audio_q;
  assign audio_sd    = tone_active;
  assign stock_level = vm_bus.sel_stock;

  assign leds[3:0] = 4'b0001 << sw_item;
  assign leds[4]   = tone_active;
  assign leds[5]   = vm_bus.error_flag;
  assign leds[6]   = (vm_bus.credit >= price_disp);
  assign leds[7]   = (vm_bus.sel_stock == '0);

  // State and change are published for observation only.
  logic unused_ok;
  assign unused_ok = ^{vm_bus.state, vm_bus.change_due};
endmodule

// File: tb/tb_vending_machine_top.sv
module tb_vending_machine_top;
  localparam int DB_MAX  = 2;
  localparam int REFRESH = 4;
  localparam int INIT    = 5;
  localparam int TDIV    = 3;
  localparam int TLEN    = 40;

  localparam int B_COIN1 = 1;
  localparam int B_COIN2 = 2;
  localparam int B_COIN5 = 4;
  localparam int B_PURCH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_coin1 = 1'b0, btn_coin2 = 1'b0, btn_coin5 = 1'b0, btn_purchase = 1'b0;
  logic [1:0] sw_item = 2'd0;
  logic       restock = 1'b0;
  wire  [6:0] seg;
  wire  [3:0] an;
  wire  [3:0] stock_level;
  wire  [7:0] leds;
  wire        audio_out, audio_sd;

  always #5 clk = ~clk;

  vending_machine_top #(
    .DEBOUNCE_MAX (DB_MAX),
    .REFRESH_COUNT(REFRESH),
    .INIT_STOCK   (INIT),
    .TONE_DIV     (TDIV),
    .TONE_LEN     (TLEN)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_coin1(btn_coin1), .btn_coin2(btn_coin2), .btn_coin5(btn_coin5),
    .btn_purchase(btn_purchase), .sw_item(sw_item), .restock(restock),
    .seg(seg), .an(an), .stock_level(stock_level), .leds(leds),
    .audio_out(audio_out), .audio_sd(audio_sd)
  );

  // Read-only view of the controller status bus.
  vending_machine_if mon ();
  assign mon.sel_item   = dut.vm_bus.sel_item;
  assign mon.sel_stock  = dut.vm_bus.sel_stock;
  assign mon.vend_item  = dut.vm_bus.vend_item;
  assign mon.vend_stock = dut.vm_bus.vend_stock;
  assign mon.vend_dec   = dut.vm_bus.vend_dec;
  assign mon.credit     = dut.vm_bus.credit;
  assign mon.change_due = dut.vm_bus.change_due;
  assign mon.state      = dut.vm_bus.state;
  assign mon.vend_pulse = dut.vm_bus.vend_pulse;
  assign mon.error_flag = dut.vm_bus.error_flag;

  // Scoreboard of expected values.
  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  // Event counters sampled on the falling edge.
  int   vend_cycles = 0, vend_rises = 0, err5_cycles = 0, errflag_cycles = 0;
  int   check_cycles = 0, audio_edges = 0;
  logic vend_prev = 1'b0, audio_prev = 1'b0;

  always @(negedge clk) begin
    vend_prev  <= mon.vend_pulse;
    audio_prev <= audio_out;
    if (mon.vend_pulse === 1'b1) begin
      vend_cycles <= vend_cycles + 1;
      if (vend_prev !== 1'b1) vend_rises <= vend_rises + 1;
    end
    if (mon.state === 3'd5) err5_cycles <= err5_cycles + 1;
    if (mon.state === 3'd5 && mon.error_flag === 1'b1) errflag_cycles <= errflag_cycles + 1;
    if (mon.state === 3'd2) check_cycles <= check_cycles + 1;
    if (audio_out !== audio_prev) audio_edges <= audio_edges + 1;
  end

  task automatic expect_val(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check_next(input logic [31:0] obs);
    exp_t e;
    tests_run++;
    assert (sb_q.size() != 0) else begin
      tests_failed++;
      $error("FAIL sb_empty observed=%0d expected=<entry>", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
    end
    $display("[TB] check %-16s observed=%0d expected=%0d", e.tag, obs, e.exp);
  endtask

  task automatic set_btn(input int mask, input logic v);
    if (mask & B_COIN1) btn_coin1    = v;
    if (mask & B_COIN2) btn_coin2    = v;
    if (mask & B_COIN5) btn_coin5    = v;
    if (mask & B_PURCH) btn_purchase = v;
  endtask

  // Hold the buttons for 'hold' clocks, release, then let everything settle.
  task automatic press(input int mask, input int hold);
    @(negedge clk);
    set_btn(mask, 1'b1);
    repeat (hold) @(negedge clk);
    set_btn(mask, 1'b0);
    repeat (14) @(negedge clk);
  endtask

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h7F;
    endcase
  endfunction

  task automatic check_display(input logic [3:0] d3, input logic [3:0] d2,
                               input logic [3:0] d1, input logic [3:0] d0);
    logic [3:0] digs [4];
    logic [3:0] an_exp;
    bit         found;
    digs[0] = d0; digs[1] = d1; digs[2] = d2; digs[3] = d3;
    for (int d = 0; d < 4; d++) begin
      an_exp = ~(4'b0001 << d);
      found  = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
        @(negedge clk);
        if (an === an_exp) found = 1'b1;
      end
      expect_val($sformatf("an_scan%0d", d), 1);
      check_next(32'(found));
      expect_val($sformatf("seg_digit%0d", d), 32'(seg_lut(digs[d])));
      check_next(32'(seg));
    end
  endtask

  int   snap_a, snap_b, snap_c;
  bit   found;
  logic [7:0] exp_credit;

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    expect_val("rst_credit", 0);    check_next(32'(mon.credit));
    expect_val("rst_state", 0);     check_next(32'(mon.state));
    expect_val("rst_stock", 5);     check_next(32'(stock_level));
    expect_val("rst_an", 4'hF);     check_next(32'(an));
    expect_val("rst_audio_sd", 0);  check_next(32'(audio_sd));
    expect_val("rst_audio_out", 0); check_next(32'(audio_out));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // $5 coin
    press(B_COIN5, 8);
    expect_val("c5_credit", 5);   check_next(32'(mon.credit));
    expect_val("c5_state", 0);    check_next(32'(mon.state));
    expect_val("c5_stock", 5);    check_next(32'(stock_level));
    expect_val("c5_onehot", 1);   check_next(32'(leds[3:0]));
    expect_val("c5_credit_ok", 1); check_next(32'(leds[6]));
    check_display(0, 5, 0, 3);

    // Buy item0 at price 3
    snap_a = vend_rises; snap_b = vend_cycles; snap_c = audio_edges;
    press(B_PURCH, 8);
    expect_val("buy0_vend_rises", 1);  check_next(32'(vend_rises - snap_a));
    expect_val("buy0_vend_cycles", 1); check_next(32'(vend_cycles - snap_b));
    expect_val("buy0_credit", 2);      check_next(32'(mon.credit));
    expect_val("buy0_change", 2);      check_next(32'(mon.change_due));
    expect_val("buy0_stock", 4);       check_next(32'(stock_level));
    expect_val("buy0_audio_sd", 1);    check_next(32'(audio_sd));
    expect_val("buy0_led_tone", 1);    check_next(32'(leds[4]));
    repeat (40) @(negedge clk);
    expect_val("tone_end_sd", 0);      check_next(32'(audio_sd));
    expect_val("tone_end_out", 0);     check_next(32'(audio_out));
    expect_val("tone_toggles_ok", 1);
    check_next(32'((audio_edges - snap_c) >= 10 && (audio_edges - snap_c) <= 16));

    // Item2 costs 6, credit 2: error for one cycle
    sw_item = 2'd2;
    snap_a = err5_cycles; snap_b = errflag_cycles; snap_c = vend_cycles;
    press(B_PURCH, 8);
    expect_val("err_state_cycles", 1); check_next(32'(err5_cycles - snap_a));
    expect_val("err_flag_cycles", 1);  check_next(32'(errflag_cycles - snap_b));
    expect_val("err_no_vend", 0);      check_next(32'(vend_cycles - snap_c));
    expect_val("err_credit", 2);       check_next(32'(mon.credit));
    expect_val("err_state", 0);        check_next(32'(mon.state));
    expect_val("err_stock", 5);        check_next(32'(stock_level));

    // Item3: drain the stock, watching the scarcity price
    sw_item = 2'd3;
    repeat (7) press(B_COIN5, 8);
    expect_val("i3_credit", 37); check_next(32'(mon.credit));
    exp_credit = 8'd37;
    for (int k = 1; k <= 4; k++) begin
      press(B_PURCH, 8);
      exp_credit = exp_credit - 8'd7;
      expect_val($sformatf("i3_buy%0d_credit", k), 32'(exp_credit)); check_next(32'(mon.credit));
      expect_val($sformatf("i3_buy%0d_stock", k), 32'(5 - k));        check_next(32'(stock_level));
    end
    check_display(0, 9, 0, 8);
    press(B_PURCH, 8);
    expect_val("i3_last_credit", 1); check_next(32'(mon.credit));
    expect_val("i3_last_stock", 0);  check_next(32'(stock_level));
    expect_val("i3_soldout_led", 1); check_next(32'(leds[7]));
    press(B_COIN5, 8);
    press(B_COIN5, 8);
    snap_a = err5_cycles;
    press(B_PURCH, 8);
    expect_val("soldout_err", 1);    check_next(32'(err5_cycles - snap_a));
    expect_val("soldout_credit", 11); check_next(32'(mon.credit));
    expect_val("soldout_stock", 0);  check_next(32'(stock_level));
    @(negedge clk);
    restock = 1'b1;
    repeat (2) @(negedge clk);
    restock = 1'b0;
    @(negedge clk);
    expect_val("restock_stock", 5);  check_next(32'(stock_level));
    expect_val("restock_led7", 0);   check_next(32'(leds[7]));
    check_display(1, 1, 0, 7);

    // Coin and purchase together: coin wins, purchase dropped
    sw_item = 2'd0;
    snap_a = check_cycles;
    press(B_COIN1 | B_PURCH, 8);
    expect_val("simul_credit", 12);  check_next(32'(mon.credit));
    expect_val("simul_no_check", 0); check_next(32'(check_cycles - snap_a));

    // Minimal 4-clock press registers once
    press(B_COIN1, 4);
    expect_val("short_press", 13);   check_next(32'(mon.credit));

    // Saturation at 99
    repeat (18) press(B_COIN5, 8);
    expect_val("sat_credit", 99);    check_next(32'(mon.credit));
    press(B_COIN1, 8);
    expect_val("sat_hold", 99);      check_next(32'(mon.credit));

    // Reset in the middle of a vend
    @(negedge clk);
    set_btn(B_PURCH, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (mon.vend_pulse === 1'b1) found = 1'b1;
    end
    expect_val("rstv_vend_seen", 1); check_next(32'(found));
    rst = 1'b0;
    @(negedge clk);
    expect_val("rstv_credit", 0);    check_next(32'(mon.credit));
    expect_val("rstv_state", 0);     check_next(32'(mon.state));
    expect_val("rstv_audio_sd", 0);  check_next(32'(audio_sd));
    for (int i = 0; i < 4; i++) begin
      sw_item = 2'(i);
      #1;
      expect_val($sformatf("rstv_stock%0d", i), 5); check_next(32'(stock_level));
    end
    set_btn(B_PURCH, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
